// File: rtl/sysclk_region_detect.sv
// Classifies the once-per-window SNES sysclk frequency measurement into a clock
// region, debounces it over consecutive windows and commits a stable region for the MCU.
module sysclk_region_detect #(
  parameter int unsigned WINDOW_CYCLES = 86000000,
  parameter int unsigned OFF_MAX       = 1000000,
  parameter int unsigned PAL_MIN       = 21200000,
  parameter int unsigned PAL_MAX       = 21360000,
  parameter int unsigned NTSC_MIN      = 21400000,
  parameter int unsigned NTSC_MAX      = 21550000,
  parameter int unsigned STABLE_COUNT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] snes_sysclk_freq,
  input  logic        irq_ack,
  output logic [1:0]  clk_class,
  output logic        class_valid,
  output logic        change_irq,
  output logic [31:0] stable_freq
);

  typedef enum logic [1:0] {
    CLS_OFF  = 2'd0,
    CLS_NTSC = 2'd1,
    CLS_PAL  = 2'd2,
    CLS_UNK  = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_QUAL = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  localparam int unsigned AW = $clog2(STABLE_COUNT + 1);
  localparam logic [AW-1:0] AGREE_MAX = AW'(STABLE_COUNT);
  localparam logic [31:0] WIN_LAST = 32'(WINDOW_CYCLES - 1);

  logic [31:0]   win_cnt;
  logic          tick;
  logic          sample;
  cls_e          cand;
  cls_e          last_cand;
  logic [AW-1:0] agree_cnt;
  logic [AW-1:0] agree_nxt;
  state_e        state;
  state_e        state_nxt;
  logic          commit;
  logic          refresh;
  logic          raise_irq;

  cls_e          clk_class_q;
  logic          class_valid_q;
  logic          change_irq_q;
  logic [31:0]   stable_freq_q;

  assign tick   = (win_cnt == WIN_LAST);
  assign sample = tick && (snes_sysclk_freq != '1);

  always_comb begin
    cand = CLS_UNK;
    if (snes_sysclk_freq <= OFF_MAX)
      cand = CLS_OFF;
    else if (snes_sysclk_freq >= PAL_MIN && snes_sysclk_freq <= PAL_MAX)
      cand = CLS_PAL;
    else if (snes_sysclk_freq >= NTSC_MIN && snes_sysclk_freq <= NTSC_MAX)
      cand = CLS_NTSC;
  end

  always_comb begin
    agree_nxt = AW'(1);
    if (cand == last_cand)
      agree_nxt = (agree_cnt >= AGREE_MAX) ? AGREE_MAX : agree_cnt + AW'(1);
  end

  // A LOCK excursion only commits directly when one sample is enough to qualify.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    if (sample) begin
      unique case (state)
        S_WAIT, S_QUAL: begin
          if (agree_nxt == AGREE_MAX) begin
            commit    = 1'b1;
            state_nxt = S_LOCK;
          end else begin
            state_nxt = S_QUAL;
          end
        end
        S_LOCK: begin
          if (cand != clk_class_q) begin
            if (agree_nxt == AGREE_MAX)
              commit = 1'b1;
            else
              state_nxt = S_QUAL;
          end
        end
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  assign refresh   = sample && (state == S_LOCK) && (cand == clk_class_q);
  assign raise_irq = commit && ((cand != clk_class_q) || !class_valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      state     <= S_WAIT;
      last_cand <= CLS_UNK;
      agree_cnt <= '0;
    end else begin
      win_cnt <= tick ? '0 : win_cnt + 32'd1;
      state   <= state_nxt;
      if (sample) begin
        last_cand <= cand;
        agree_cnt <= agree_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_class_q   <= CLS_UNK;
      class_valid_q <= 1'b0;
      stable_freq_q <= '0;
      change_irq_q  <= 1'b0;
    end else begin
      if (commit) begin
        clk_class_q   <= cand;
        class_valid_q <= 1'b1;
      end
      if (commit || refresh)
        stable_freq_q <= snes_sysclk_freq;
      // A new commit outranks an acknowledge landing in the same cycle.
      if (raise_irq)
        change_irq_q <= 1'b1;
      else if (irq_ack)
        change_irq_q <= 1'b0;
    end
  end

  assign clk_class   = clk_class_q;
  assign class_valid = class_valid_q;
  assign change_irq  = change_irq_q;
  assign stable_freq = stable_freq_q;

endmodule

// File: tb/tb_sysclk_region_detect.sv
module tb_sysclk_region_detect;

  localparam int unsigned W = 16;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;
  localparam logic [31:0] NT   = 32'd21477272;
  localparam logic [31:0] NT2  = 32'd21477000;
  localparam logic [31:0] PL   = 32'd21281370;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] freq = 32'hFFFF_FFFF;
  logic        irq_ack = 1'b0;
  logic [1:0]  clk_class;
  logic        class_valid;
  logic        change_irq;
  logic [31:0] stable_freq;

  typedef struct {
    string       name;
    int unsigned at;
    logic [1:0]  cls;
    logic        vld;
    logic        irq;
    logic [31:0] sf;
  } exp_t;

  exp_t        sb[$];
  int unsigned tcyc = 0;
  int          checks = 0;
  int          passed = 0;

  sysclk_region_detect #(
    .WINDOW_CYCLES(W),
    .STABLE_COUNT (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .snes_sysclk_freq(freq),
    .irq_ack         (irq_ack),
    .clk_class       (clk_class),
    .class_valid     (class_valid),
    .change_irq      (change_irq),
    .stable_freq     (stable_freq)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input logic [1:0] c, input logic v,
                              input logic i, input logic [31:0] s);
    exp_t e;
    e.name = n; e.at = 0; e.cls = c; e.vld = v; e.irq = i; e.sf = s;
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_t t;
    t = e;
    t.at = tcyc + 1;
    sb.push_back(t);
  endtask

  always @(negedge clk) begin
    tcyc++;
    while (sb.size() > 0 && sb[0].at < tcyc) begin
      checks++;
      $display("FAIL %s: expectation for cycle %0d never compared", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end
    while (sb.size() > 0 && sb[0].at == tcyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (clk_class === e.cls && class_valid === e.vld && change_irq === e.irq &&
          stable_freq === e.sf)
        passed++;
      else
        $display("FAIL %s: got cls=%0d vld=%0b irq=%0b sf=%0d, expected cls=%0d vld=%0b irq=%0b sf=%0d",
                 e.name, clk_class, class_valid, change_irq, stable_freq,
                 e.cls, e.vld, e.irq, e.sf);
    end
  end

  task automatic window(input logic [31:0] f, input bit hold, input int ack_at,
                        input exp_t mid, input exp_t fin);
    for (int j = 0; j < int'(W); j++) begin
      @(negedge clk);
      freq    = (hold || j == int'(W) - 1) ? f : ~f;
      irq_ack = (j == ack_at);
      @(posedge clk);
      if (j == ack_at && j < int'(W) - 1) push(mid);
    end
    #1 irq_ack = 1'b0;
    push(fin);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    push(mk("reset_immediate", 2'd3, 1'b0, 1'b0, 32'd0));
    #1;
    checks++;
    if (clk_class === 2'd3 && class_valid === 1'b0 && change_irq === 1'b0 &&
        stable_freq === 32'd0)
      passed++;
    else
      $display("FAIL reset_async: got cls=%0d vld=%0b irq=%0b sf=%0d",
               clk_class, class_valid, change_irq, stable_freq);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t R;
    R = mk("unused", 2'd3, 1'b0, 1'b0, 32'd0);

    apply_reset();
    for (int k = 0; k < 6; k++)
      window(SENT, 1'b1, -1, R, mk("sentinel_hold", 2'd3, 1'b0, 1'b0, 32'd0));

    apply_reset();
    window(NT, 1'b0, -1, R, mk("ntsc_tick1", 2'd3, 1'b0, 1'b0, 32'd0));
    window(NT, 1'b0, -1, R, mk("ntsc_tick2", 2'd3, 1'b0, 1'b0, 32'd0));
    window(NT, 1'b0, -1, R, mk("ntsc_commit", 2'd1, 1'b1, 1'b1, NT));
    window(NT2, 1'b0, 3, mk("irq_ack_clear", 2'd1, 1'b1, 1'b0, NT),
           mk("lock_refresh", 2'd1, 1'b1, 1'b0, NT2));
    window(NT2, 1'b0, 5, mk("ack_while_clear", 2'd1, 1'b1, 1'b0, NT2),
           mk("lock_refresh2", 2'd1, 1'b1, 1'b0, NT2));

    window(PL, 1'b0, -1, R, mk("pal_excursion1", 2'd1, 1'b1, 1'b0, NT2));
    window(PL, 1'b0, -1, R, mk("pal_excursion2", 2'd1, 1'b1, 1'b0, NT2));
    window(NT, 1'b0, -1, R, mk("ntsc_back1", 2'd1, 1'b1, 1'b0, NT2));
    window(NT, 1'b0, -1, R, mk("ntsc_back2", 2'd1, 1'b1, 1'b0, NT2));
    window(NT, 1'b0, -1, R, mk("ntsc_recommit_noirq", 2'd1, 1'b1, 1'b0, NT));

    window(PL, 1'b0, -1, R, mk("pal_sustain1", 2'd1, 1'b1, 1'b0, NT));
    window(PL, 1'b0, -1, R, mk("pal_sustain2", 2'd1, 1'b1, 1'b0, NT));
    window(PL, 1'b0, W - 1, R, mk("pal_commit_ack_same", 2'd2, 1'b1, 1'b1, PL));

    window(32'd1000000, 1'b0, 0, mk("ack_pal", 2'd2, 1'b1, 1'b0, PL),
           mk("offmax_1", 2'd2, 1'b1, 1'b0, PL));
    window(32'd1000000, 1'b0, -1, R, mk("offmax_2", 2'd2, 1'b1, 1'b0, PL));
    window(32'd1000000, 1'b0, -1, R, mk("offmax_commit", 2'd0, 1'b1, 1'b1, 32'd1000000));

    window(32'd1000001, 1'b0, 0, mk("ack_off", 2'd0, 1'b1, 1'b0, 32'd1000000),
           mk("offmax_p1_1", 2'd0, 1'b1, 1'b0, 32'd1000000));
    window(32'd1000001, 1'b0, -1, R, mk("offmax_p1_2", 2'd0, 1'b1, 1'b0, 32'd1000000));
    window(32'd1000001, 1'b0, -1, R, mk("offmax_p1_commit", 2'd3, 1'b1, 1'b1, 32'd1000001));

    window(32'd21550000, 1'b0, 0, mk("ack_unk", 2'd3, 1'b1, 1'b0, 32'd1000001),
           mk("ntscmax_1", 2'd3, 1'b1, 1'b0, 32'd1000001));
    window(32'd21550000, 1'b0, -1, R, mk("ntscmax_2", 2'd3, 1'b1, 1'b0, 32'd1000001));
    window(32'd21550000, 1'b0, -1, R, mk("ntscmax_commit", 2'd1, 1'b1, 1'b1, 32'd21550000));

    window(32'd21550001, 1'b0, 0, mk("ack_ntsc", 2'd1, 1'b1, 1'b0, 32'd21550000),
           mk("ntscmax_p1_1", 2'd1, 1'b1, 1'b0, 32'd21550000));
    window(32'd21550001, 1'b0, -1, R, mk("ntscmax_p1_2", 2'd1, 1'b1, 1'b0, 32'd21550000));
    window(32'd21550001, 1'b0, -1, R, mk("ntscmax_p1_commit", 2'd3, 1'b1, 1'b1, 32'd21550001));

    window(32'd21200000, 1'b0, 0, mk("ack_unk2", 2'd3, 1'b1, 1'b0, 32'd21550001),
           mk("palmin_1", 2'd3, 1'b1, 1'b0, 32'd21550001));
    window(32'd21200000, 1'b0, -1, R, mk("palmin_2", 2'd3, 1'b1, 1'b0, 32'd21550001));
    window(32'd21200000, 1'b0, -1, R, mk("palmin_commit", 2'd2, 1'b1, 1'b1, 32'd21200000));

    window(SENT, 1'b1, -1, R, mk("sentinel_locked", 2'd2, 1'b1, 1'b1, 32'd21200000));

    window(NT, 1'b0, -1, R, mk("midqual_1", 2'd2, 1'b1, 1'b1, 32'd21200000));
    window(NT, 1'b0, -1, R, mk("midqual_2", 2'd2, 1'b1, 1'b1, 32'd21200000));
    apply_reset();
    window(NT, 1'b0, -1, R, mk("after_rst_1", 2'd3, 1'b0, 1'b0, 32'd0));
    window(NT, 1'b0, -1, R, mk("after_rst_2", 2'd3, 1'b0, 1'b0, 32'd0));
    window(NT, 1'b0, -1, R, mk("after_rst_commit", 2'd1, 1'b1, 1'b1, NT));

    repeat (3) @(negedge clk);
    checks++;
    if (clk_class === 2'd1 && class_valid === 1'b1 && change_irq === 1'b1 &&
        stable_freq === NT)
      passed++;
    else
      $display("FAIL final_state: got cls=%0d vld=%0b irq=%0b sf=%0d",
               clk_class, class_valid, change_irq, stable_freq);
    while (sb.size() > 0) begin
      checks++;
      $display("FAIL %s: expectation left uncompared", sb[0].name);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sysclk_region_detect.md
# sysclk_region_detect

Downstream consumer of the 32-bit SNES sysclk frequency measurement (rising-edge count per measurement window). Samples the measurement once per window and classifies it into a clock region: OFF, NTSC, PAL or UNKNOWN. Debounces the classification over consecutive windows and commits a stable region with a sticky change flag for the MCU. The committed region drives region-dependent logic and is exposed in the MCU status register.

## Interface
Parameters:
- WINDOW_CYCLES, 86000000: sample period in clk cycles; matches the measurement window length.
- OFF_MAX, 1000000: counts ≤ this classify as OFF.
- PAL_MIN, 21200000 / PAL_MAX, 21360000: inclusive PAL band.
- NTSC_MIN, 21400000 / NTSC_MAX, 21550000: inclusive NTSC band. Bands must not overlap.
- STABLE_COUNT, 3: consecutive identical classifications required to commit (≥1).

Ports:
- clk  in  1  system clock; same domain as the frequency measurement.
- rst_n  in  1  asynchronous, active-low reset.
- snes_sysclk_freq  in  32  latest measured count; 32'hFFFFFFFF = no measurement yet.
- irq_ack  in  1  single-cycle pulse; clears change_irq.
- clk_class  out  2  committed region: 0 OFF, 1 NTSC, 2 PAL, 3 UNKNOWN.
- class_valid  out  1  high once any region has been committed.
- change_irq  out  1  sticky; set on each commit that changes clk_class or sets class_valid.
- stable_freq  out  32  measurement value at the last agreeing sample while locked.

## Operation
- Window counter win_cnt (32 bit) counts 0..WINDOW_CYCLES-1, then wraps to 0. tick = (win_cnt == WINDOW_CYCLES-1).
- On tick, the candidate class is formed combinationally from snes_sysclk_freq (unsigned compares):
  - 32'hFFFFFFFF → sample ignored. No state changes except win_cnt.
  - ≤ OFF_MAX → OFF; within PAL band → PAL; within NTSC band → NTSC; otherwise → UNKNOWN.
- Agreement tracking: last_cand (2 bit) and agree_cnt (saturates at STABLE_COUNT).
  - cand == last_cand → agree_cnt + 1, saturating.
  - cand != last_cand → last_cand = cand, agree_cnt = 1.
- FSM:
  - WAIT (reset): no valid sample yet. The first non-sentinel tick moves to QUAL.
  - QUAL: when the new agree_cnt reaches STABLE_COUNT, commit and go to LOCK.
  - LOCK: a tick with cand == clk_class updates stable_freq. A tick with cand != clk_class goes to QUAL; clk_class, class_valid and stable_freq hold.
- Commit: clk_class = cand, class_valid = 1, stable_freq = snes_sysclk_freq. change_irq is set only if cand != clk_class or class_valid was 0. Re-committing the same class after a QUAL excursion does not raise change_irq.
- With STABLE_COUNT = 1, the first valid tick commits immediately (WAIT→LOCK in one tick).
- change_irq: set on a qualifying commit and cleared by irq_ack. If commit and irq_ack occur in the same cycle, change_irq is 1 (set wins). irq_ack while change_irq is 0 has no effect.

## Timing
- Reset values (asynchronous on rst_n low):
  - outputs: clk_class = 3, class_valid = 0, change_irq = 0, stable_freq = 0.
  - internal: win_cnt = 0, agree_cnt = 0, last_cand = 3, state = WAIT.
- All outputs are registered. Effects of a tick are visible the cycle after the tick edge.
- First tick occurs at cycle WINDOW_CYCLES-1 after reset release.
- Commit latency from the first matching valid sample: (STABLE_COUNT-1)·WINDOW_CYCLES cycles + 1.
- snes_sysclk_freq is sampled only on tick; changes between ticks are ignored.
- Reset mid-qualification discards agree_cnt and restarts in WAIT.
- irq_ack clears change_irq in 1 cycle.

## Test plan
Use WINDOW_CYCLES = 16 and STABLE_COUNT = 3 unless stated.
- Reset with freq = 32'hFFFFFFFF held for 100 cycles → clk_class = 3, class_valid = 0, change_irq = 0 throughout.
- freq = 21477272 from reset → commit on the 3rd tick (edge at cycle 47) → clk_class = 1, class_valid = 1, change_irq = 1, stable_freq = 21477272. Then irq_ack → change_irq = 0 next cycle.
- Locked NTSC, freq → 21281370 (PAL) for 2 ticks then back to NTSC → no change to clk_class and no irq. Sustained PAL for 3 ticks → clk_class = 2, change_irq = 1.
- Boundaries: freq = OFF_MAX → OFF; OFF_MAX+1 → UNKNOWN; NTSC_MAX → NTSC; NTSC_MAX+1 → UNKNOWN; PAL_MIN → PAL (each for 3 ticks).
- irq_ack asserted on the same cycle as a class-change commit → change_irq = 1 afterwards.
- rst_n pulsed low mid-QUAL (after 2 agreeing ticks) → all outputs at reset values immediately. After release, commit requires 3 fresh ticks.
